m_mem_master: RTL and testbench

- M-stage initiator that drives the word-addressed data memory port.
- Turns pipeline load/store ops (lw/lh/lhu/lb/lbu/sw/sh/sb) into req/ack memory transactions with byte enables.
- Extracts and extends load data, detects misalignment, bounds each transaction with a timeout.
- Stalls the pipeline until the access completes.

---
 rtl/m_mem_master_pkg.sv | 45 ++++
 rtl/m_load_ext.sv | 29 ++
 rtl/m_mem_master.sv | 197 +++++++++++++++++++
 tb/tb_m_mem_master.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_mem_master_pkg.sv
// Shared encodings for the M-stage memory master:
// op types, FSM states, byte-enable constants.
package m_mem_master_pkg;

  typedef enum logic [3:0] {
    OP_LW  = 4'd0,
    OP_LH  = 4'd1,
    OP_LHU = 4'd2,
    OP_LB  = 4'd3,
    OP_LBU = 4'd4,
    OP_SW  = 4'd5,
    OP_SH  = 4'd6,
    OP_SB  = 4'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_B0   = 4'b0001;

  function automatic logic is_store(op_e op);
    return op inside {OP_SW, OP_SH, OP_SB};
  endfunction

  function automatic logic is_word(op_e op);
    return op inside {OP_LW, OP_SW};
  endfunction

  function automatic logic is_half(op_e op);
    return op inside {OP_LH, OP_LHU, OP_SH};
  endfunction

  function automatic logic misaligned(op_e op,
                                      logic [1:0] lo);
    return (is_word(op) && (lo != 2'b00)) ||
           (is_half(op) && lo[0]);
  endfunction

endpackage

// File: rtl/m_load_ext.sv
// Load lane select plus sign/zero extension.
// Purely combinational; shareable by any load path.
module m_load_ext
  import m_mem_master_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lo_i,
  input  op_e         op_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    sh = word_i >> {lo_i, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    unique case (op_i)
      OP_LB:   data_o = {{24{b[7]}}, b};
      OP_LBU:  data_o = {24'h0, b};
      OP_LH:   data_o = {{16{h[15]}}, h};
      OP_LHU:  data_o = {16'h0, h};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/m_mem_master.sv
// M-stage data memory initiator (req/ack, timeout).
// Define STORE_TRACE_EN to print each acked store.
module m_mem_master
  import m_mem_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [3:0]        op_type,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [31:0]       op_wdata,
  input  logic [31:0]       op_pc,
  output logic              stall,
  output logic [31:0]       rd_data,
  output logic              done,
  output logic              addr_exc,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_byteen,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wd_q, wd_d;
  logic [3:0]        be_q, be_d;
  logic              we_q, we_d;
  logic              exc_q, exc_d;
  logic              berr_q, berr_d;
  logic [31:0]       rd_q, rd_d;

  op_e         op_in;
  logic        mis_in;
  logic [3:0]  be_in;
  logic [31:0] wd_in;
  logic [31:0] ext;
  logic        cnt_hit;

  assign op_in   = op_e'(op_type);
  assign mis_in  = misaligned(op_in, op_addr[1:0]);
  assign cnt_hit = (cnt_q == CNT_MAX);

  // Stores replicate data to every lane.
  always_comb begin
    be_in = BE_WORD;
    wd_in = op_wdata;
    unique case (1'b1)
      (op_in == OP_SB): begin
        be_in = BE_B0 << op_addr[1:0];
        wd_in = {4{op_wdata[7:0]}};
      end
      (op_in == OP_SH): begin
        be_in = op_addr[1] ? BE_HI : BE_LO;
        wd_in = {2{op_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  m_load_ext u_ext (
    .word_i (mem_rdata),
    .lo_i   (addr_q[1:0]),
    .op_i   (op_q),
    .data_o (ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (op_valid)
          state_d = mis_in ? S_DONE : S_REQ;
      S_REQ:
        if (mem_ack || cnt_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req    = (state_q == S_REQ);
    mem_we     = mem_req & we_q;
    mem_addr   = mem_req ?
                 {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_wdata  = mem_req ? wd_q : '0;
    mem_byteen = mem_req ? be_q : '0;
    done       = (state_q == S_DONE);
    addr_exc   = done & exc_q;
    bus_err    = done & berr_q;
    stall      = op_valid & ~done;
    rd_data    = rd_q;
  end

  // Ack beats timeout when both land in one cycle.
  always_comb begin
    cnt_d  = '0;
    op_d   = op_q;
    addr_d = addr_q;
    wd_d   = wd_q;
    be_d   = be_q;
    we_d   = we_q;
    exc_d  = exc_q;
    berr_d = berr_q;
    rd_d   = rd_q;
    unique case (state_q)
      S_IDLE:
        if (op_valid) begin
          op_d   = op_in;
          addr_d = op_addr;
          wd_d   = wd_in;
          be_d   = be_in;
          we_d   = is_store(op_in);
          exc_d  = mis_in;
          berr_d = 1'b0;
        end
      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_ack) begin
          if (!we_q) rd_d = ext;
        end else if (cnt_hit) begin
          berr_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      op_q   <= OP_LW;
      addr_q <= '0;
      wd_q   <= '0;
      be_q   <= '0;
      we_q   <= 1'b0;
      exc_q  <= 1'b0;
      berr_q <= 1'b0;
      rd_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      addr_q <= addr_d;
      wd_q   <= wd_d;
      be_q   <= be_d;
      we_q   <= we_d;
      exc_q  <= exc_d;
      berr_q <= berr_d;
      rd_q   <= rd_d;
    end
  end

`ifdef STORE_TRACE_EN
  logic [31:0] pc_q;
  logic [31:0] merged;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pc_q <= '0;
    else if (state_q == S_IDLE && op_valid)
      pc_q <= op_pc;
  end

  always_comb begin
    merged = '0;
    for (int i = 0; i < 4; i++)
      if (be_q[i]) merged[8*i +: 8] = wd_q[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (state_q == S_REQ && mem_ack && we_q)
      $display("@%h: *%h <= %h",
               pc_q, addr_q, merged);
  end
`else
  logic pc_unused;
  assign pc_unused = ^op_pc;
`endif

endmodule

// File: tb/tb_m_mem_master.sv
// Scoreboard bench for m_mem_master: byte-level
// reference memory, random ops, random ack delays.
module tb_m_mem_master;
  import m_mem_master_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op_type;
  logic [31:0] op_addr, op_wdata, op_pc;
  logic        stall, done, addr_exc, bus_err;
  logic [31:0] rd_data;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byteen;

  always #5 clk = ~clk;

  m_mem_master #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_type(op_type),
    .op_addr(op_addr), .op_wdata(op_wdata),
    .op_pc(op_pc), .stall(stall),
    .rd_data(rd_data), .done(done),
    .addr_exc(addr_exc), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byteen(mem_byteen), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          lat;
    int          issue;
    bit          exc;
    bit          berr;
    logic [31:0] rd;
  } exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } mexp_t;

  exp_t  exp_q[$];
  mexp_t mexp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ack_at = 1;
  int req_cnt = 0;

  logic [7:0]  shadow [256] = '{default: 8'h00};
  logic [31:0] ram [64] = '{default: 32'h0};
  logic [31:0] last_rd = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  function automatic int size_of(op_e t);
    if (t inside {OP_LB, OP_LBU, OP_SB}) return 1;
    if (t inside {OP_LH, OP_LHU, OP_SH}) return 2;
    return 4;
  endfunction

  // Memory responder: acks on the ack_at-th req cycle,
  // throws random acks while no request is up.
  initial begin
    mexp_t m;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        req_cnt++;
        if (req_cnt == 1) begin
          if (mexp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_req: got %h want none",
                     mem_addr);
          end else begin
            m = mexp_q.pop_front();
            chk("mem_we", 32'(mem_we), 32'(m.we));
            chk("mem_addr", mem_addr, m.addr);
            chk("mem_byteen", 32'(mem_byteen), 32'(m.be));
            if (m.we) chk("mem_wdata", mem_wdata, m.wd);
          end
        end
        mem_ack = (req_cnt == ack_at);
        mem_rdata = ram[mem_addr[7:2]];
        if (mem_ack && mem_we)
          for (int i = 0; i < 4; i++)
            if (mem_byteen[i])
              ram[mem_addr[7:2]][8*i +: 8] =
                mem_wdata[8*i +: 8];
      end else begin
        req_cnt = 0;
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  // Completion monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got 1 want 0");
        end else begin
          e = exp_q.pop_front();
          chk("latency", 32'(cyc - e.issue), 32'(e.lat));
          chk("addr_exc", 32'(addr_exc), 32'(e.exc));
          chk("bus_err", 32'(bus_err), 32'(e.berr));
          chk("rd_data", rd_data, e.rd);
          chk("stall_done", 32'(stall), 32'h0);
        end
      end
    end
  end

  // Reference model + driver. ack=0 means never ack.
  task automatic run_op(op_e t, logic [31:0] a,
                        logic [31:0] d, int ack, int gap);
    exp_t  e;
    mexp_t m;
    int    sz;
    bit    st, mis, sgn, ok;
    logic [31:0] v;
    bit    seen;
    if (gap > 0) begin
      op_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    sz  = size_of(t);
    st  = t inside {OP_SW, OP_SH, OP_SB};
    sgn = t inside {OP_LB, OP_LH};
    mis = (a % sz) != 0;
    ok  = !mis && ack != 0;
    m.we   = st;
    m.addr = a & ~32'h3;
    m.be   = st ? 4'(((1 << sz) - 1) << (a % 4)) : 4'hF;
    for (int i = 0; i < 4; i++)
      m.wd[8*i +: 8] = d[8*(i % sz) +: 8];
    if (ok && st)
      for (int i = 0; i < sz; i++)
        shadow[a + i] = d[8*i +: 8];
    if (ok && !st) begin
      v = 32'h0;
      for (int i = 0; i < sz; i++)
        v[8*i +: 8] = shadow[a + i];
      if (sgn && v[8*sz-1])
        v = v | (32'hFFFF_FFFF << (8 * sz));
      last_rd = v;
    end
    e.lat   = mis ? 1 : (ack == 0 ? TO + 1 : ack + 1);
    e.issue = cyc;
    e.exc   = mis;
    e.berr  = !mis && ack == 0;
    e.rd    = last_rd;
    exp_q.push_back(e);
    if (!mis) mexp_q.push_back(m);
    ack_at   = ack;
    op_type  = t;
    op_addr  = a;
    op_wdata = d;
    op_pc    = $urandom & ~32'h3;
    op_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      chk("stall_busy", 32'(stall), 32'h1);
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_wait: got none want done");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid();
    run_op_start();
    repeat (3) @(negedge clk);
    chk("rst_pre_req", 32'(mem_req), 32'h1);
    #2;
    reset = 1'b0;
    op_valid = 1'b0;
    #1;
    exp_q.delete();
    mexp_q.delete();
    last_rd = 32'h0;
    chk("rst_mid_req", 32'(mem_req), 32'h0);
    chk("rst_mid_stall", 32'(stall), 32'h0);
    chk("rst_mid_done", 32'(done), 32'h0);
    chk("rst_mid_rd", rd_data, 32'h0);
    @(negedge clk);
    chk("rst_mid_done2", 32'(done), 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op_start();
    mexp_t m;
    m.we = 1'b0;
    m.addr = 32'h40;
    m.be = 4'hF;
    m.wd = 32'h0;
    mexp_q.push_back(m);
    ack_at   = 0;
    op_type  = OP_LW;
    op_addr  = 32'h40;
    op_wdata = 32'h0;
    op_valid = 1'b1;
  endtask

  initial begin
    op_e t;
    int  a, r, ack, sz;
    reset = 1'b0;
    op_valid = 1'b0;
    op_type = 4'h0;
    op_addr = 32'h0;
    op_wdata = 32'h0;
    op_pc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_be", 32'(mem_byteen), 32'h0);
    chk("rst_rd", rd_data, 32'h0);
    chk("rst_exc", 32'(addr_exc), 32'h0);
    chk("rst_berr", 32'(bus_err), 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_op(OP_SW, 32'h10, 32'h1234_5678, 2, 0);
    run_op(OP_SW, 32'h20, 32'h80F0_7F01, 1, 0);
    run_op(OP_LB, 32'h23, 32'h0, 2, 0);
    chk("lb_val", rd_data, 32'hFFFF_FF80);
    run_op(OP_LBU, 32'h23, 32'h0, 1, 1);
    chk("lbu_val", rd_data, 32'h0000_0080);
    run_op(OP_LH, 32'h20, 32'h0, 3, 0);
    chk("lh_val", rd_data, 32'h0000_7F01);
    run_op(OP_LHU, 32'h22, 32'h0, 1, 0);
    chk("lhu_val", rd_data, 32'h0000_80F0);
    run_op(OP_SB, 32'h13, 32'h0000_00AB, 3, 0);
    run_op(OP_SH, 32'h12, 32'h0000_BEEF, 1, 0);
    run_op(OP_LW, 32'h10, 32'h0, 2, 0);
    chk("merge_val", rd_data, 32'hBEEF_5678);
    run_op(OP_LW, 32'h21, 32'h0, 1, 0);
    run_op(OP_SH, 32'h13, 32'h0, 1, 0);
    run_op(OP_LW, 32'h20, 32'h0, 0, 0);
    run_op(OP_SW, 32'h24, 32'hDEAD_BEEF, 0, 1);
    run_op(OP_LW, 32'h20, 32'h0, TO, 0);
    chk("ack_at_limit", rd_data, 32'h80F0_7F01);

    for (int n = 0; n < 150; n++) begin
      t  = op_e'($urandom_range(0, 7));
      sz = size_of(t);
      a  = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) a = a & ~(sz - 1);
      r = $urandom_range(0, 19);
      if (r < 16)       ack = $urandom_range(1, 4);
      else if (r == 16) ack = 0;
      else if (r == 17) ack = TO;
      else              ack = $urandom_range(1, TO);
      run_op(t, a, $urandom, ack, $urandom_range(0, 2));
    end

    reset_mid();
    run_op(OP_LW, 32'h20, 32'h0, 2, 0);
    op_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
    chk("mexp_q_empty", 32'(mexp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
